pc_progress_watchdog: RTL and testbench
=======================================

# pc_progress_watchdog

Synthesizable forward-progress monitor for the pipelined RV32 core. It samples the fetch PC every enabled cycle and raises a sticky alarm when the PC stays at one value for a parameterised number of cycles (stuck). It also raises the alarm when the PC keeps revisiting a small set of recent addresses (tight loop). It sits beside the core, outside the datapath, and its outputs feed a debug/status register block and simulation benches.

## Interface
- `XLEN`, 32: PC width.
- `CNT_W`, 16: width of run/statistics counters.
- `STALL_LIMIT`, 16: consecutive equal samples that trigger a stuck alarm; legal range 1..2^CNT_W-1.
- `HIST_DEPTH`, 4: number of previously left PCs kept for loop detection; legal range 1..16.
- `LOOP_LIMIT`, 8: consecutive history hits that trigger a loop alarm; legal range ≥1.

- `clk` input 1: clock.
- `reset` input 1: synchronous, active-high reset.
- `sample_en` input 1: take a PC sample this cycle. When low, all state holds.
- `pc_in` input XLEN: current fetch PC from the core.
- `clear` input 1: synchronous alarm/tracking clear.
- `alarm` output 1: sticky alarm flag.
- `alarm_cause` output 2: bit0 = stuck, bit1 = loop. Sticky; bits OR-accumulate.
- `alarm_pc` output XLEN: PC captured at the first alarm.
- `run_count` output CNT_W: current consecutive-equal run length.
- `max_run` output CNT_W: longest run seen since reset.
- `change_count` output CNT_W: number of PC changes; wraps.

## Operation
- States:
  - EMPTY: no previous sample held.
  - TRACK: previous sample held, no alarm.
  - ALARM: alarm set; tracking continues.
- Reset: every register and output is 0, history entries are invalid, state is EMPTY.
- EMPTY with `sample_en`:
  - `last_pc` ← `pc_in`, `run_count` ← 0, state → TRACK.
  - No comparison is made on this sample.
- TRACK/ALARM with `sample_en`, when `pc_in == last_pc`:
  - `run_count` increments and saturates at 2^CNT_W-1.
  - `max_run` ← max(`max_run`, new `run_count`).
- TRACK/ALARM with `sample_en`, when `pc_in != last_pc`:
  - `hit` = `pc_in` matches any valid history entry, evaluated before the push.
  - Push `last_pc` into the history shift register; the oldest entry is dropped.
  - `last_pc` ← `pc_in`, `run_count` ← 0, `change_count` +1 (wraps).
  - `loop_streak` ← `hit` ? saturating `loop_streak`+1 : 0.
- Stuck event: the new `run_count` equals `STALL_LIMIT`.
- Loop event: the new `loop_streak` equals `LOOP_LIMIT`.
- Any event:
  - `alarm` ← 1 and the event's cause bit is set.
  - `alarm_pc` ← `pc_in`, only if `alarm` was 0 beforehand.
  - TRACK → ALARM.
  - Both events in one cycle are impossible, because stuck requires equal and loop requires a change.
- `clear` (synchronous):
  - Zeroes `alarm`, `alarm_cause`, `alarm_pc`, `run_count` and `loop_streak`, invalidates the history, state → EMPTY.
  - `max_run` and `change_count` are kept.
  - `clear` has priority over `sample_en` in the same cycle; that sample is discarded.
- `reset` has priority over `clear`.
- Only ALARM → EMPTY via `clear` leaves the ALARM state.

## Timing
- All outputs are registered. Updates appear after the rising edge on which the qualifying sample is taken (latency 1).
- Stuck example: constant PC sampled from edge 0 gives `run_count` = k after edge k. `alarm` is high after edge `STALL_LIMIT`.
- A `sample_en` gap does not break a run: the next sample is compared against the held `last_pc`.
- Saturated `run_count` does not re-fire a stuck event, because the equality holds only once.
- `alarm_pc` and the first cause are frozen until `clear` or `reset`. Later events only OR in cause bits.
- A `reset` or `clear` asserted mid-run discards the partial run and history. The next enabled sample is treated as a first sample.

## Test plan
- **Stuck detection:** STALL_LIMIT=16; `pc_in`=0x50 held with `sample_en`=1 for 20 cycles.
  - `alarm` rises after the 17th sample (edge 16) with `alarm_cause`=01 and `alarm_pc`=0x50.
  - `run_count`=19 at the end; `max_run`=19.
- **Normal progress:** PC increments by 4 from 0x0 for 100 cycles.
  - `alarm`=0, `run_count`=0, `change_count`=99, `max_run`=0.
- **Two-address loop:** HIST_DEPTH=4, LOOP_LIMIT=8; PC alternates 0x40/0x44 every sample.
  - The first change misses; `loop_streak` reaches 8 on the 10th sample.
  - `alarm_cause`=10 and `alarm_pc` = the 10th sample's PC (0x44).
- **Loop wider than history:** PC cycles through 6 distinct addresses with HIST_DEPTH=4.
  - No loop alarm; `loop_streak` stays 0.
- **Clear and stuck together:** `clear` asserted on the edge where stuck would fire.
  - `alarm` stays 0, state is EMPTY and `run_count`=0.
  - A further 16 equal samples after the first reload raise the alarm again; `max_run` is retained across the clear.
- **Enable gaps and reset mid-run:** stuck PC 0x50 with `sample_en` gated 50% still alarms after 16 enabled equal samples.
  - `reset` asserted at run 10 zeroes every output, including `max_run`.

Source files
------------

// File: rtl/pc_progress_watchdog_if.sv
// Sample/status bundle between a PC source and the forward-progress watchdog.
// The master drives samples and clear; the slave returns alarm and run statistics.
interface pc_progress_watchdog_if #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 16
);
    logic             sample_en;
    logic [XLEN-1:0]  pc_in;
    logic             clear;
    logic             alarm;
    logic [1:0]       alarm_cause;
    logic [XLEN-1:0]  alarm_pc;
    logic [CNT_W-1:0] run_count;
    logic [CNT_W-1:0] max_run;
    logic [CNT_W-1:0] change_count;

    modport master (
        output sample_en, pc_in, clear,
        input  alarm, alarm_cause, alarm_pc, run_count, max_run, change_count
    );

    modport slave (
        input  sample_en, pc_in, clear,
        output alarm, alarm_cause, alarm_pc, run_count, max_run, change_count
    );
endinterface

// File: rtl/pc_progress_watchdog.sv
// Forward-progress monitor: flags a PC that stays put (stuck) or keeps
// revisiting a short history of recently left PCs (tight loop). Alarm is sticky.
module pc_progress_watchdog #(
    parameter int XLEN        = 32,
    parameter int CNT_W       = 16,
    parameter int STALL_LIMIT = 16,
    parameter int HIST_DEPTH  = 4,
    parameter int LOOP_LIMIT  = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    pc_progress_watchdog_if.slave wd
);
    typedef enum logic [1:0] {EMPTY, TRACK, ALARM} state_t;

    localparam logic [CNT_W-1:0] CNT_MAX   = '1;
    localparam logic [CNT_W-1:0] STALL_LIM = CNT_W'(STALL_LIMIT);
    localparam logic [CNT_W-1:0] LOOP_LIM  = CNT_W'(LOOP_LIMIT);

    state_t           state_reg;
    logic [XLEN-1:0]  last_pc_reg;
    logic [XLEN-1:0]  alarm_pc_reg;
    logic [CNT_W-1:0] run_count_reg;
    logic [CNT_W-1:0] max_run_reg;
    logic [CNT_W-1:0] change_count_reg;
    logic [CNT_W-1:0] loop_streak_reg;
    logic             alarm_reg;
    logic [1:0]       cause_reg;
    logic [XLEN-1:0]  hist_pc_reg [HIST_DEPTH];
    logic [HIST_DEPTH-1:0] hist_valid_reg;

    logic [HIST_DEPTH-1:0] hit_vec;
    logic             hit;
    logic             same_pc;
    logic [CNT_W-1:0] run_next;
    logic [CNT_W-1:0] streak_next;
    logic             stuck_evt;
    logic             loop_evt;

    // History lookup happens against the contents before this cycle's push.
    generate
        for (genvar gi = 0; gi < HIST_DEPTH; gi++) begin : g_hist_cmp
            assign hit_vec[gi] = hist_valid_reg[gi] && (hist_pc_reg[gi] == wd.pc_in);
        end
    endgenerate

    assign hit = |hit_vec;

    always_comb begin
        same_pc     = (wd.pc_in == last_pc_reg);
        run_next    = (run_count_reg == CNT_MAX) ? run_count_reg : run_count_reg + CNT_W'(1);
        streak_next = '0;
        if (hit) begin
            streak_next = (loop_streak_reg == CNT_MAX) ? loop_streak_reg
                                                        : loop_streak_reg + CNT_W'(1);
        end
        // A saturated run never re-crosses the limit, so the event fires once.
        stuck_evt = same_pc && (run_count_reg != CNT_MAX) && (run_next == STALL_LIM);
        loop_evt  = !same_pc && (streak_next == LOOP_LIM);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg        <= EMPTY;
            last_pc_reg      <= '0;
            alarm_pc_reg     <= '0;
            run_count_reg    <= '0;
            max_run_reg      <= '0;
            change_count_reg <= '0;
            loop_streak_reg  <= '0;
            alarm_reg        <= 1'b0;
            cause_reg        <= 2'b00;
            hist_valid_reg   <= '0;
            for (int i = 0; i < HIST_DEPTH; i++) begin
                hist_pc_reg[i] <= '0;
            end
        end else if (wd.clear) begin
            state_reg       <= EMPTY;
            alarm_pc_reg    <= '0;
            run_count_reg   <= '0;
            loop_streak_reg <= '0;
            alarm_reg       <= 1'b0;
            cause_reg       <= 2'b00;
            hist_valid_reg  <= '0;
        end else if (wd.sample_en) begin
            case (state_reg)
                EMPTY: begin
                    last_pc_reg   <= wd.pc_in;
                    run_count_reg <= '0;
                    state_reg     <= TRACK;
                end
                default: begin
                    if (same_pc) begin
                        run_count_reg <= run_next;
                        if (run_next > max_run_reg) begin
                            max_run_reg <= run_next;
                        end
                    end else begin
                        for (int i = HIST_DEPTH - 1; i > 0; i--) begin
                            hist_pc_reg[i]    <= hist_pc_reg[i-1];
                            hist_valid_reg[i] <= hist_valid_reg[i-1];
                        end
                        hist_pc_reg[0]    <= last_pc_reg;
                        hist_valid_reg[0] <= 1'b1;
                        last_pc_reg       <= wd.pc_in;
                        run_count_reg     <= '0;
                        change_count_reg  <= change_count_reg + CNT_W'(1);
                        loop_streak_reg   <= streak_next;
                    end
                    if (stuck_evt || loop_evt) begin
                        alarm_reg <= 1'b1;
                        cause_reg <= cause_reg | {loop_evt, stuck_evt};
                        if (!alarm_reg) begin
                            alarm_pc_reg <= wd.pc_in;
                        end
                        state_reg <= ALARM;
                    end
                end
            endcase
        end
    end

    assign wd.alarm        = alarm_reg;
    assign wd.alarm_cause  = cause_reg;
    assign wd.alarm_pc     = alarm_pc_reg;
    assign wd.run_count    = run_count_reg;
    assign wd.max_run      = max_run_reg;
    assign wd.change_count = change_count_reg;
endmodule

// File: tb/tb_pc_progress_watchdog.sv
// Directed and randomized bench for pc_progress_watchdog, checked against a
// queue-based behavioural model of the stuck/loop rules.
module tb_pc_progress_watchdog;
    localparam int XLEN = 32;
    localparam int CNT_W = 16;
    localparam int STALL_LIMIT = 16;
    localparam int HIST_DEPTH = 4;
    localparam int LOOP_LIMIT = 8;
    localparam int CMAX = 65535;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    pc_progress_watchdog_if #(.XLEN(XLEN), .CNT_W(CNT_W)) bus ();

    pc_progress_watchdog #(
        .XLEN(XLEN), .CNT_W(CNT_W), .STALL_LIMIT(STALL_LIMIT),
        .HIST_DEPTH(HIST_DEPTH), .LOOP_LIMIT(LOOP_LIMIT)
    ) dut (
        .clk(clk),
        .reset(rst),
        .wd(bus.slave)
    );

    int n_vec = 0;
    int n_bad = 0;
    int n_step = 0;

    // Reference model state
    bit        m_have;
    bit [31:0] m_last;
    int        m_run, m_max, m_chg, m_streak;
    bit        m_alarm;
    bit [1:0]  m_cause;
    bit [31:0] m_apc;
    bit [31:0] m_hist[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_clear_tracking();
        m_have = 0; m_run = 0; m_streak = 0;
        m_alarm = 0; m_cause = 2'b00; m_apc = 0;
        m_hist.delete();
    endtask

    task automatic model_update(input bit en, input bit [31:0] pc, input bit clr, input bit rs);
        bit stuck, loop_e, hit;
        stuck = 0; loop_e = 0; hit = 0;
        if (rs) begin
            model_clear_tracking();
            m_last = 0; m_max = 0; m_chg = 0;
        end else if (clr) begin
            model_clear_tracking();
        end else if (en) begin
            if (!m_have) begin
                m_have = 1; m_last = pc; m_run = 0;
            end else if (pc == m_last) begin
                stuck = (m_run != CMAX) && (m_run + 1 == STALL_LIMIT);
                m_run = (m_run == CMAX) ? CMAX : m_run + 1;
                if (m_run > m_max) m_max = m_run;
            end else begin
                foreach (m_hist[i]) if (m_hist[i] == pc) hit = 1;
                m_hist.push_front(m_last);
                if (m_hist.size() > HIST_DEPTH) void'(m_hist.pop_back());
                m_last = pc; m_run = 0;
                m_chg = (m_chg + 1) % (CMAX + 1);
                m_streak = hit ? ((m_streak == CMAX) ? CMAX : m_streak + 1) : 0;
                loop_e = hit && (m_streak == LOOP_LIMIT);
            end
            if (stuck || loop_e) begin
                if (!m_alarm) m_apc = pc;
                m_alarm = 1;
                m_cause = m_cause | {loop_e, stuck};
            end
        end
    endtask

    // One clocked transaction: drive, clock, model, then compare all outputs.
    task automatic step(input bit en, input bit [31:0] pc, input bit clr, input bit rs);
        bus.sample_en = en; bus.pc_in = pc; bus.clear = clr; rst = rs;
        @(posedge clk);
        model_update(en, pc, clr, rs);
        #1;
        n_step++;
        $display("step %0d en=%b clr=%b rst=%b pc=%h | alarm=%b cause=%b apc=%h run=%0d max=%0d chg=%0d",
                 n_step, en, clr, rs, pc, bus.alarm, bus.alarm_cause, bus.alarm_pc,
                 bus.run_count, bus.max_run, bus.change_count);
        chk("alarm",        {31'd0, bus.alarm},       {31'd0, m_alarm});
        chk("alarm_cause",  {30'd0, bus.alarm_cause}, {30'd0, m_cause});
        chk("alarm_pc",     bus.alarm_pc,             m_apc);
        chk("run_count",    {16'd0, bus.run_count},   32'(m_run));
        chk("max_run",      {16'd0, bus.max_run},     32'(m_max));
        chk("change_count", {16'd0, bus.change_count}, 32'(m_chg));
    endtask

    initial begin
        bit [31:0] pc;
        bit [31:0] addrs[6];
        bit en;
        int enabled;
        bus.sample_en = 0; bus.pc_in = 0; bus.clear = 0;
        m_last = 0; m_max = 0; m_chg = 0;
        model_clear_tracking();

        // Reset state
        step(0, 0, 0, 1);
        step(0, 0, 0, 1);
        chk("reset_alarm", {31'd0, bus.alarm}, 32'd0);
        chk("reset_run", {16'd0, bus.run_count}, 32'd0);

        // Stuck detection: 20 samples of 0x50
        for (int i = 0; i < 20; i++) begin
            step(1, 32'h50, 0, 0);
            if (i == 15) chk("stuck_not_yet", {31'd0, bus.alarm}, 32'd0);
            if (i == 16) chk("stuck_rise", {31'd0, bus.alarm}, 32'd1);
        end
        chk("stuck_cause", {30'd0, bus.alarm_cause}, 32'd1);
        chk("stuck_pc", bus.alarm_pc, 32'h50);
        chk("stuck_run", {16'd0, bus.run_count}, 32'd19);
        chk("stuck_max", {16'd0, bus.max_run}, 32'd19);

        // Normal progress
        step(0, 0, 0, 1);
        for (int i = 0; i < 100; i++) step(1, 32'(i * 4), 0, 0);
        chk("prog_alarm", {31'd0, bus.alarm}, 32'd0);
        chk("prog_run", {16'd0, bus.run_count}, 32'd0);
        chk("prog_chg", {16'd0, bus.change_count}, 32'd99);
        chk("prog_max", {16'd0, bus.max_run}, 32'd0);

        // Two-address loop
        step(0, 0, 0, 1);
        for (int i = 0; i < 10; i++) begin
            step(1, (i % 2 == 0) ? 32'h40 : 32'h44, 0, 0);
            if (i == 8) chk("loop_not_yet", {31'd0, bus.alarm}, 32'd0);
        end
        chk("loop_alarm", {31'd0, bus.alarm}, 32'd1);
        chk("loop_cause", {30'd0, bus.alarm_cause}, 32'd2);
        chk("loop_pc", bus.alarm_pc, 32'h44);

        // Loop wider than history
        step(0, 0, 0, 1);
        for (int i = 0; i < 6; i++) addrs[i] = 32'h1000 + 32'(i * 16);
        for (int i = 0; i < 60; i++) step(1, addrs[i % 6], 0, 0);
        chk("wide_loop_alarm", {31'd0, bus.alarm}, 32'd0);

        // Clear on the edge where stuck would fire
        step(0, 0, 0, 1);
        for (int i = 0; i < 16; i++) step(1, 32'h50, 0, 0);
        step(1, 32'h50, 1, 0);
        chk("clr_alarm", {31'd0, bus.alarm}, 32'd0);
        chk("clr_run", {16'd0, bus.run_count}, 32'd0);
        chk("clr_max_kept", {16'd0, bus.max_run}, 32'd15);
        step(1, 32'h50, 0, 0);
        for (int i = 0; i < 16; i++) step(1, 32'h50, 0, 0);
        chk("clr_realarm", {31'd0, bus.alarm}, 32'd1);
        chk("clr_max16", {16'd0, bus.max_run}, 32'd16);

        // Enable gaps, bounded by a cycle budget
        step(0, 0, 0, 1);
        enabled = 0;
        for (int i = 0; i < 400 && enabled < 17; i++) begin
            en = $urandom_range(0, 1) == 1;
            if (en) enabled++;
            step(en, 32'h50, 0, 0);
        end
        chk("gap_enabled_17", 32'(enabled), 32'd17);
        chk("gap_alarm", {31'd0, bus.alarm}, 32'd1);

        // Reset mid-run
        step(0, 0, 0, 1);
        for (int i = 0; i < 11; i++) step(1, 32'h50, 0, 0);
        chk("mid_run10", {16'd0, bus.run_count}, 32'd10);
        step(1, 32'h50, 0, 1);
        chk("mid_reset_max", {16'd0, bus.max_run}, 32'd0);
        chk("mid_reset_run", {16'd0, bus.run_count}, 32'd0);

        // Randomized traffic
        pc = 32'h100;
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 3) == 0) pc = 32'h100 + 32'($urandom_range(0, 7) * 4);
            step($urandom_range(0, 9) < 8, pc,
                 $urandom_range(0, 99) < 2, $urandom_range(0, 199) < 1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
